// File: rtl/spi_target_bridge.sv
// SPI mode-0 target that lets an external host read/write the internal byte bus.
// Define SPI_TARGET_AUTOINC_EN for multi-byte bursts with an incrementing address.
module spi_target_bridge #(
  parameter int unsigned ADDR_BYTES  = 2,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    spi_clk,
  input  logic                    spi_cs_n,
  input  logic                    spi_mosi,
  output logic                    spi_miso,
  output logic                    spi_miso_oe,
  output logic                    bus_req,
  output logic                    bus_we,
  output logic [8*ADDR_BYTES-1:0] bus_addr,
  output logic [7:0]              bus_wdata,
  input  logic [7:0]              bus_rdata,
  input  logic                    bus_ack
);

  localparam int unsigned AW  = 8 * ADDR_BYTES;
  localparam int unsigned ACW = (ADDR_BYTES > 1) ? $clog2(ADDR_BYTES) : 1;
  localparam logic [ACW-1:0] AddrLast = ACW'(ADDR_BYTES - 1);
  localparam logic [7:0] CmdWrite = 8'h02;
  localparam logic [7:0] CmdRead  = 8'h03;

  typedef enum logic [2:0] {StIdle, StCmd, StAddr, StDummy, StData, StIgnore} frame_state_e;
  typedef enum logic [0:0] {BIdle, BReq} bus_state_e;

  // Input synchronizers
  logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
  logic                   sclk_prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      sclk_prev_q <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_clk};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
      sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
    end
  end

  logic sclk_s, cs_active, mosi_s, sclk_rise, sclk_fall;
  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign cs_active = ~cs_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;

  assign spi_miso_oe = cs_active;

  // Frame-side state
  frame_state_e   state_q, state_d;
  logic [2:0]     bit_cnt_q, bit_cnt_d;
  logic [7:0]     rx_q, rx_d, tx_q, tx_d;
  logic           miso_q, miso_d;
  logic [AW-1:0]  addr_q, addr_d;
  logic [ACW-1:0] addr_cnt_q, addr_cnt_d;
  logic           is_write_q, is_write_d;
  logic [7:0]     rd_buf_q, rd_buf_d;
  logic           rd_valid_q, rd_valid_d;

  // Bus-side state
  bus_state_e     bstate_q, bstate_d;
  logic           req_d, we_d;
  logic [AW-1:0]  baddr_d;
  logic [7:0]     wdata_d;
  logic           cur_want_q, cur_want_d;
  logic           pend_q, pend_d, pend_we_q, pend_we_d, pend_want_q, pend_want_d;
  logic [AW-1:0]  pend_addr_q, pend_addr_d;
  logic [7:0]     pend_wdata_q, pend_wdata_d;

  // Frame -> bus request handoff
  logic           new_req, new_we, new_want, drop_read, ack_hit;
  logic [AW-1:0]  new_addr, addr_shift;
  logic [7:0]     new_wdata, rx_byte, load_byte;

  assign rx_byte    = {rx_q[6:0], mosi_s};
  assign addr_shift = AW'({addr_q, rx_byte});
  // Only an ack for a read the current frame still waits on may fill the TX buffer
  assign ack_hit    = (bstate_q == BReq) & bus_ack & cur_want_q & ~bus_we;

  assign spi_miso = miso_q;

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    rx_d       = rx_q;
    tx_d       = tx_q;
    miso_d     = miso_q;
    addr_d     = addr_q;
    addr_cnt_d = addr_cnt_q;
    is_write_d = is_write_q;
    rd_buf_d   = rd_buf_q;
    rd_valid_d = rd_valid_q;
    new_req    = 1'b0;
    new_we     = 1'b0;
    new_addr   = addr_q;
    new_wdata  = rx_byte;
    new_want   = 1'b0;
    drop_read  = 1'b0;
    load_byte  = 8'hFF;

    if (ack_hit) begin
      rd_buf_d   = bus_rdata;
      rd_valid_d = 1'b1;
    end

    if (!cs_active) begin
      // Deselect wins over any edge in the same cycle; the partial byte is lost
      state_d    = StIdle;
      bit_cnt_d  = 3'd0;
      rx_d       = 8'h00;
      tx_d       = 8'h00;
      miso_d     = 1'b0;
      rd_valid_d = 1'b0;
      drop_read  = 1'b1;
    end else if (state_q == StIdle) begin
      state_d    = StCmd;
      bit_cnt_d  = 3'd0;
      addr_cnt_d = '0;
      miso_d     = 1'b0;
    end else begin
      if (sclk_rise) begin
        rx_d      = rx_byte;
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          unique case (state_q)
            StCmd: begin
              if (rx_byte == CmdWrite) begin
                is_write_d = 1'b1;
                state_d    = StAddr;
              end else if (rx_byte == CmdRead) begin
                is_write_d = 1'b0;
                state_d    = StAddr;
              end else begin
                state_d = StIgnore;
              end
            end
            StAddr: begin
              addr_d     = addr_shift;
              addr_cnt_d = addr_cnt_q + ACW'(1);
              if (addr_cnt_q == AddrLast) begin
                if (is_write_q) begin
                  state_d = StData;
                end else begin
                  state_d  = StDummy;
                  new_req  = 1'b1;
                  new_addr = addr_shift;
                  new_want = 1'b1;
                end
              end
            end
            StDummy: state_d = StData;
            StData: begin
              if (is_write_q) begin
                new_req   = 1'b1;
                new_we    = 1'b1;
                new_addr  = addr_q;
                new_wdata = rx_byte;
`ifdef SPI_TARGET_AUTOINC_EN
                addr_d    = addr_q + AW'(1);
`else
                state_d   = StIgnore;
`endif
              end else begin
`ifndef SPI_TARGET_AUTOINC_EN
                state_d = StIgnore;
`endif
              end
            end
            default: ;
          endcase
        end
      end

      if (sclk_fall) begin
        if (state_q == StData && !is_write_q) begin
          if (bit_cnt_q == 3'd0) begin
            // First fall of a read byte: the ack deadline; missing data shifts 0xFF
            load_byte  = rd_valid_q ? rd_buf_q : 8'hFF;
            miso_d     = load_byte[7];
            tx_d       = {load_byte[6:0], 1'b0};
            rd_valid_d = 1'b0;
            drop_read  = 1'b1;
`ifdef SPI_TARGET_AUTOINC_EN
            addr_d     = addr_q + AW'(1);
            new_req    = 1'b1;
            new_addr   = addr_q + AW'(1);
            new_want   = 1'b1;
`endif
          end else begin
            miso_d = tx_q[7];
            tx_d   = {tx_q[6:0], 1'b0};
          end
        end else begin
          miso_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      bit_cnt_q  <= 3'd0;
      rx_q       <= 8'h00;
      tx_q       <= 8'h00;
      miso_q     <= 1'b0;
      addr_q     <= '0;
      addr_cnt_q <= '0;
      is_write_q <= 1'b0;
      rd_buf_q   <= 8'h00;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      rx_q       <= rx_d;
      tx_q       <= tx_d;
      miso_q     <= miso_d;
      addr_q     <= addr_d;
      addr_cnt_q <= addr_cnt_d;
      is_write_q <= is_write_d;
      rd_buf_q   <= rd_buf_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  always_comb begin
    bstate_d     = bstate_q;
    req_d        = bus_req;
    we_d         = bus_we;
    baddr_d      = bus_addr;
    wdata_d      = bus_wdata;
    cur_want_d   = cur_want_q;
    pend_d       = pend_q;
    pend_we_d    = pend_we_q;
    pend_want_d  = pend_want_q;
    pend_addr_d  = pend_addr_q;
    pend_wdata_d = pend_wdata_q;

    if (drop_read) begin
      cur_want_d  = 1'b0;
      pend_want_d = 1'b0;
    end

    unique case (bstate_q)
      BIdle: begin
        if (pend_q) begin
          bstate_d   = BReq;
          req_d      = 1'b1;
          we_d       = pend_we_q;
          baddr_d    = pend_addr_q;
          wdata_d    = pend_wdata_q;
          cur_want_d = pend_want_d;
          pend_d     = 1'b0;
        end else if (new_req) begin
          bstate_d   = BReq;
          req_d      = 1'b1;
          we_d       = new_we;
          baddr_d    = new_addr;
          wdata_d    = new_wdata;
          cur_want_d = new_want;
        end
      end
      BReq: begin
        if (bus_ack) begin
          bstate_d   = BIdle;
          req_d      = 1'b0;
          cur_want_d = 1'b0;
        end
      end
      default: bstate_d = BIdle;
    endcase

    // A request that cannot go out directly waits in the single pending slot
    if (new_req && !(bstate_q == BIdle && !pend_q)) begin
      pend_d       = 1'b1;
      pend_we_d    = new_we;
      pend_addr_d  = new_addr;
      pend_wdata_d = new_wdata;
      pend_want_d  = new_want;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bstate_q     <= BIdle;
      bus_req      <= 1'b0;
      bus_we       <= 1'b0;
      bus_addr     <= '0;
      bus_wdata    <= 8'h00;
      cur_want_q   <= 1'b0;
      pend_q       <= 1'b0;
      pend_we_q    <= 1'b0;
      pend_want_q  <= 1'b0;
      pend_addr_q  <= '0;
      pend_wdata_q <= 8'h00;
    end else begin
      bstate_q     <= bstate_d;
      bus_req      <= req_d;
      bus_we       <= we_d;
      bus_addr     <= baddr_d;
      bus_wdata    <= wdata_d;
      cur_want_q   <= cur_want_d;
      pend_q       <= pend_d;
      pend_we_q    <= pend_we_d;
      pend_want_q  <= pend_want_d;
      pend_addr_q  <= pend_addr_d;
      pend_wdata_q <= pend_wdata_d;
    end
  end

endmodule
